// File: rtl/traffic_timed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_timed_ctrl
// Brief    : Timed highway/country junction controller with pedestrian walk.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_timed_ctrl #(
  parameter int GREEN_MIN   = 8,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 1,
  parameter int COUNTRY_MIN = 4,
  parameter int COUNTRY_MAX = 12,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] Highway,
  output logic [1:0] Country,
  output logic [2:0] state,
  output logic       walk
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  localparam logic [1:0] c_red    = 2'b00;
  localparam logic [1:0] c_yellow = 2'b01;
  localparam logic [1:0] c_green  = 2'b10;

  // Last timer value of each phase; the phase is left on the edge that sees it.
  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] c_cmin_last   = CNT_W'(COUNTRY_MIN - 1);
  localparam logic [CNT_W-1:0] c_cmax_last   = CNT_W'(COUNTRY_MAX - 1);
  localparam logic [CNT_W-1:0] c_timer_max   = '1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic             r_ped_pending;
  logic             r_walk;
  logic             w_enter_ctry;

  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = (r_timer >= c_green_last && (x || r_ped_pending)) ? S1 : S0;
      S1: w_next = (r_timer == c_yellow_last) ? S2 : S1;
      S2: w_next = (r_timer == c_allred_last) ? S3 : S2;
      // Country green ends on demand loss after the minimum, or on timeout.
      S3: w_next = ((r_timer >= c_cmin_last && !x) || r_timer == c_cmax_last) ? S4 : S3;
      S4: w_next = (r_timer == c_yellow_last) ? S5 : S4;
      S5: w_next = (r_timer == c_allred_last) ? S0 : S5;
      default: w_next = S0;
    endcase
  end

  assign w_enter_ctry = (r_state == S2) && (w_next == S3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S0;
      r_timer       <= '0;
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_timer != c_timer_max) begin
        r_timer <= r_timer + 1'b1;
      end
      // A press on the serving edge is kept for the following round.
      if (ped_req) begin
        r_ped_pending <= 1'b1;
      end else if (w_enter_ctry) begin
        r_ped_pending <= 1'b0;
      end
      if (w_enter_ctry) begin
        r_walk <= r_ped_pending;
      end else if (w_next != S3) begin
        r_walk <= 1'b0;
      end
    end
  end

  always_comb begin
    Highway = c_red;
    Country = c_red;
    case (r_state)
      S0:      Highway = c_green;
      S1:      Highway = c_yellow;
      S3:      Country = c_green;
      S4:      Country = c_yellow;
      default: ;
    endcase
  end

  assign state = r_state;
  assign walk  = r_walk;

endmodule
`default_nettype wire

// File: tb/tb_traffic_timed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_timed_ctrl
// Brief    : Directed + random bench against a phase/dwell reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_timed_ctrl;

  localparam int GREEN_MIN   = 8;
  localparam int YELLOW_T    = 3;
  localparam int ALLRED_T    = 1;
  localparam int COUNTRY_MIN = 4;
  localparam int COUNTRY_MAX = 12;
  localparam int CNT_W       = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       x       = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] Highway;
  logic [1:0] Country;
  logic [2:0] state;
  logic       walk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase index, cycles spent in phase, request and walk.
  int m_p;
  int m_cnt;
  bit m_pend;
  bit m_walk;
  int hw_of [6] = '{2, 1, 0, 0, 0, 0};
  int ct_of [6] = '{0, 0, 0, 2, 1, 0};

  always #5 clk = ~clk;

  traffic_timed_ctrl #(
    .GREEN_MIN  (GREEN_MIN),
    .YELLOW_T   (YELLOW_T),
    .ALLRED_T   (ALLRED_T),
    .COUNTRY_MIN(COUNTRY_MIN),
    .COUNTRY_MAX(COUNTRY_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst_n),
    .x      (x),
    .ped_req(ped_req),
    .Highway(Highway),
    .Country(Country),
    .state  (state),
    .walk   (walk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_cnt = 0; m_pend = 0; m_walk = 0;
  endtask

  function automatic int dwell(input int p);
    case (p)
      1, 4:    return YELLOW_T;
      2, 5:    return ALLRED_T;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input logic xv, input logic pv);
    int  n;
    bit  leave;
    n = m_cnt + 1;
    case (m_p)
      0:       leave = (n >= GREEN_MIN) && (xv || m_pend);
      3:       leave = ((n >= COUNTRY_MIN) && !xv) || (n == COUNTRY_MAX);
      default: leave = (n == dwell(m_p));
    endcase
    if (leave && m_p == 2) begin
      m_walk = m_pend;
      m_pend = pv;
    end else begin
      m_pend = m_pend | pv;
      if (leave && m_p == 3) m_walk = 0;
    end
    if (leave) begin
      m_p   = (m_p + 1) % 6;
      m_cnt = 0;
    end else begin
      m_cnt = n;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(m_p));
    chk({tag, "_hwy"}, 32'(Highway), 32'(hw_of[m_p]));
    chk({tag, "_ctry"}, 32'(Country), 32'(ct_of[m_p]));
    chk({tag, "_walk"}, 32'(walk), 32'(m_walk));
    chk({tag, "_safety"}, 32'(Highway != 2'b00 && Country != 2'b00), 32'd0);
  endtask

  task automatic step(input logic xv, input logic pv);
    x = xv;
    ped_req = pv;
    @(posedge clk);
    model_edge(xv, pv);
    #1;
    check_outputs("cyc");
  endtask

  // 2 ns low pulse between edges; reset values must appear inside the pulse.
  task automatic reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_hwy", 32'(Highway), 32'd2);
    chk("rst_ctry", 32'(Country), 32'd0);
    chk("rst_walk", 32'(walk), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int durs[$];
    int exp_durs [7] = '{8, 3, 1, 12, 3, 1, 8};
    int run;
    int prev;
    int s3_len [2];
    int s3_walk [2];
    int r;
    int guard;

    model_reset();

    // 1: idle highway green
    x = 0;
    reset_pulse();
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    chk("t1_idle", 32'(state), 32'd0);

    // 2: continuous demand, measured phase lengths
    x = 1;
    reset_pulse();
    run = 1; prev = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      if (32'(state) == prev) run++;
      else begin durs.push_back(run); run = 1; prev = 32'(state); end
    end
    for (int i = 0; i < 7; i++)
      chk("t2_dur", (i < durs.size()) ? durs[i] : -1, exp_durs[i]);

    // 3: demand withdrawn before minimum green
    x = 0;
    reset_pulse();
    for (int i = 1; i <= 30; i++) step((i >= 2 && i <= 5), 1'b0);
    chk("t3_state", 32'(state), 32'd0);
    chk("t3_hwy", 32'(Highway), 32'd2);

    // 4: pedestrian-only round
    reset_pulse();
    s3_len[0] = 0; s3_walk[0] = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, i == 2);
      if (state == 3'd3) s3_len[0]++;
      if (walk) s3_walk[0]++;
    end
    chk("t4_s3_len", s3_len[0], 4);
    chk("t4_walk_len", s3_walk[0], 4);
    chk("t4_back_s0", 32'(state), 32'd0);

    // 5: early drop of x, press on the serving edge deferred to next round
    reset_pulse();
    s3_len = '{0, 0}; s3_walk = '{0, 0};
    r = 0; prev = 0; guard = 0;
    while (r < 2 && guard < 150) begin
      step((r == 0) ? !(m_p == 3 && m_cnt >= 5) : 1'b0,
           (r == 0) && (m_p == 2) && (m_cnt == ALLRED_T - 1));
      if (state == 3'd3) begin
        s3_len[r]++;
        if (walk) s3_walk[r] = 1;
      end else if (prev == 3) r++;
      prev = 32'(state);
      guard++;
    end
    chk("t5_rounds", r, 2);
    chk("t5_s3_len0", s3_len[0], 6);
    chk("t5_walk0", s3_walk[0], 0);
    chk("t5_walk1", s3_walk[1], 1);
    chk("t5_s3_len1", s3_len[1], COUNTRY_MIN);

    // 6: asynchronous reset during walk
    reset_pulse();
    guard = 0;
    step(1'b0, 1'b1);
    while (!(state == 3'd3 && walk) && guard < 60) begin
      step(1'b0, 1'b0);
      guard++;
    end
    chk("t6_walk_pre", 32'(walk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_walk", 32'(walk), 32'd0);
    chk("t6_hwy", 32'(Highway), 32'd2);
    chk("t6_ctry", 32'(Country), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    chk("t6_no_stale", 32'(state), 32'd0);

    // Random traffic, presses and occasional resets against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else step(($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_timed_ctrl.md
Name: traffic_timed_ctrl

Overview:
Parametrised next-generation highway/country-road traffic light controller with configurable phase timing. It adds minimum-green enforcement, a yellow phase, an all-red clearance phase, and a maximum country-green timeout. It also adds a latched pedestrian request with a walk indication. It sits at the junction top level and drives the two light heads directly from the car sensor and the pedestrian button.

Parameters:
GREEN_MIN, 8, minimum highway-green dwell in cycles (>=1)
YELLOW_T, 3, yellow dwell in cycles for either road (>=1)
ALLRED_T, 1, all-red clearance dwell in cycles (>=1)
COUNTRY_MIN, 4, minimum country-green dwell in cycles (>=1)
COUNTRY_MAX, 12, maximum country-green dwell in cycles (>=COUNTRY_MIN)
CNT_W, 4, phase timer width; every timing parameter must be <= 2^CNT_W

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
x  input  1  country-road car sensor, level-sensitive, not latched
ped_req  input  1  pedestrian button, single-cycle pulse or level, latched internally
Highway  output  2  highway light: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN
Country  output  2  country light, same encoding
state  output  3  current FSM state code
walk  output  1  pedestrian walk lamp

Behaviour:
- Reset: rst=0 takes effect immediately, with no clock edge needed.
  - Reset values: state=S0, timer=0, ped_pending=0, walk=0, Highway=GREEN, Country=RED.
  - Release is synchronous to the next clk rise.
- States (code, Highway/Country):
  - S0=0 HWY_GREEN (GREEN/RED)
  - S1=1 HWY_YELLOW (YELLOW/RED)
  - S2=2 ALLRED_A (RED/RED)
  - S3=3 CTRY_GREEN (RED/GREEN)
  - S4=4 CTRY_YELLOW (RED/YELLOW)
  - S5=5 ALLRED_B (RED/RED)
  - Codes 6 and 7 are illegal and recover to S0 on the next edge.
- Highway, Country and state are decoded from the state register (Moore); no input-to-output combinational path. walk is a register.
- Timer:
  - Cleared to 0 on every state change; otherwise increments each cycle, saturating at 2^CNT_W-1.
  - A state with dwell T is left on the edge where timer==T-1, so it is held exactly T cycles.
- Transitions:
  - S0->S1 when timer>=GREEN_MIN-1 and (x or ped_pending). Otherwise stay in S0 indefinitely.
  - S1->S2 after YELLOW_T cycles.
  - S2->S3 after ALLRED_T cycles.
  - S3->S4 when (timer>=COUNTRY_MIN-1 and x==0) or timer==COUNTRY_MAX-1. The timeout applies even with x held high.
  - S4->S5 after YELLOW_T cycles.
  - S5->S0 after ALLRED_T cycles.
- Pedestrian:
  - ped_pending is set on any edge with ped_req=1, in any state.
  - ped_pending is cleared on the S2->S3 edge. If ped_req=1 on that same edge, set wins and the request is served on the next round.
  - walk is set on the S2->S3 edge if ped_pending was 1, and cleared on the S3->S4 edge. walk is never 1 outside S3.
- A ped-only request (x=0) gives a country-green of exactly COUNTRY_MIN cycles.
- Safety invariant: Highway and Country are never both non-RED in the same cycle.
- Reset mid-phase from any state aborts immediately to the reset values, and clears any pending request.

Test Plan:
1. Defaults, rst pulsed low for 2 ns between clock edges -> Highway=2'b10, Country=2'b00, state=0, walk=0 within the pulse; with x=0 the block stays in S0 for 50 cycles.
2. x=1 held from reset release -> S0 for 8 cycles, S1 3, S2 1, S3 12 (timeout), S4 3, S5 1. The block then returns to S0 and holds 8 cycles before S1 again.
3. x=1 only during S0 cycles 2-5 then 0 -> no transition; state stays 0 with Highway=GREEN.
4. x=0, one-cycle ped_req at S0 cycle 2 -> S1 entered after cycle 8. S3 lasts exactly 4 cycles with walk=1 throughout; walk=0 and ped_pending=0 afterwards, and the block returns to S0 and stays.
5. x=1 into S3, x dropped at S3 cycle 6 -> S3 lasts 6 cycles then S4. A ped_req on the S2->S3 edge gives walk=0 this round and walk=1 on the following round.
6. rst asserted in S3 with walk=1 -> state=0, walk=0, Highway=GREEN and Country=RED at once; after release, x=0 keeps the block in S0, so no stale pedestrian request is served.
